muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Bus bundle for the multiply/divide unit: operation request, HI/LO moves,
// and the status/result outputs (busy, done, dbz, hi, lo).
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, SrcA, SrcB, mthi, mtlo, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, SrcA, SrcB, mthi, mtlo, wdata,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Ports: clk, rst_n (async active-low), bus (muldiv_unit_if.slave).
module muldiv_unit (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        bz_q, bz_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    // op[1] selects divide, op[0] selects signed
    logic        is_div, is_sgn;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        in_sgn;
    logic [31:0] a_mag, b_mag;

    assign is_div = op_q[1];
    assign is_sgn = op_q[0];
    assign in_sgn = bus.op[0];

    assign a_mag = (in_sgn && bus.SrcA[31]) ? (~bus.SrcA + 32'd1) : bus.SrcA;
    assign b_mag = (in_sgn && bus.SrcB[31]) ? (~bus.SrcB + 32'd1) : bus.SrcB;

    // Shift-add: acc = {partial, multiplier}; low bit gates the add.
    assign mul_sum  = {1'b0, acc_q[63:32]}
                    + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}.
    assign div_sh   = {acc_q[63:32], acc_q[31]};
    assign div_diff = {1'b0, div_sh} - {2'b00, b_q};
    assign div_next = div_diff[33]
                    ? {div_sh[31:0], acc_q[30:0], 1'b0}
                    : {div_diff[31:0], acc_q[30:0], 1'b1};

    assign prod_fix = (is_sgn && (sa_q ^ sb_q)) ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = (is_sgn && (sa_q ^ sb_q))
                    ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = (is_sgn && sa_q)
                    ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = 5'd0;
                    op_d    = bus.op;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    sa_d    = bus.SrcA[31];
                    sb_d    = bus.SrcB[31];
                    bz_d    = (bus.SrcB == 32'd0);
                    acc_d   = bus.op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            CALC: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (bz_q) begin
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit with a cycle-level
// arithmetic reference model and directed literal cases.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic chk_en;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dbz;
    logic [64:0] m_pend;

    // Returns {dbz, hi, lo} computed with plain arithmetic.
    function automatic logic [64:0] model_res(
        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin
                p = ua * ub;
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, cur_hi, cur_lo};
                q = 32'(ua / ub);
                r = 32'(ua % ub);
                return {1'b0, r, q};
            end
            default: begin
                if (b == 32'd0) return {1'b1, cur_hi, cur_lo};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, 32'(sr), 32'(sq)};
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_pend = '0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_busy) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 33) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dbz  = m_pend[64];
                    m_hi   = m_pend[63:32];
                    m_lo   = m_pend[31:0];
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_pend = model_res(bus.op, bus.SrcA, bus.SrcB, m_hi, m_lo);
            end else begin
                if (bus.mthi) m_hi = bus.wdata;
                if (bus.mtlo) m_lo = bus.wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("dbz",  32'(bus.dbz),  32'(m_dbz));
            chk("hi",   bus.hi, m_hi);
            chk("lo",   bus.lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
    endtask

    // Issues an op and waits for done; poke_at>0 pulses start+mthi then.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at);
        int k;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        seen = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            idle_inputs();
            bus.op   = 2'($urandom);
            bus.SrcA = $urandom;
            bus.SrcB = $urandom;
            if (poke_at > 0 && k == poke_at) begin
                bus.start = 1'b1;
                bus.mthi  = 1'b1;
                bus.wdata = $urandom;
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(k - 1), 32'd33);
        idle_inputs();
    endtask

    task automatic do_move(input logic h, input logic l,
                           input logic [31:0] d);
        @(negedge clk);
        bus.mthi  = h;
        bus.mtlo  = l;
        bus.wdata = d;
        @(negedge clk);
        idle_inputs();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        idle_inputs();
        bus.op    = 2'd0;
        bus.SrcA  = 32'd0;
        bus.SrcB  = 32'd0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // First start on the first edge after reset release.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.SrcA  = 32'hFFFF_FFFF;
        bus.SrcB  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("first_start_busy", 32'(bus.busy), 32'd1);
        idle_inputs();
        repeat (33) @(negedge clk);
        chk("multu_done", 32'(bus.done), 32'd1);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);
        chk("model_multu_hi", m_hi, 32'hFFFF_FFFE);

        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFEB);

        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(2'b10, 32'd100, 32'd7, 0);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);
        chk("model_divu_hi", m_hi, 32'd2);

        do_move(1'b1, 1'b0, 32'h11);
        do_move(1'b0, 1'b1, 32'h22);
        chk("mthi", bus.hi, 32'h11);
        chk("mtlo", bus.lo, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, 0);
        chk("dbz_flag", 32'(bus.dbz), 32'd1);
        chk("dbz_hi", bus.hi, 32'h11);
        chk("dbz_lo", bus.lo, 32'h22);
        @(negedge clk);
        chk("dbz_clear", 32'(bus.dbz), 32'd0);

        do_move(1'b1, 1'b1, 32'hA5A5_5A5A);
        chk("mt_both_hi", bus.hi, 32'hA5A5_5A5A);
        chk("mt_both_lo", bus.lo, 32'hA5A5_5A5A);

        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'h0000_0000);
        chk("ovf_dbz", 32'(bus.dbz), 32'd0);
        @(negedge clk);
        chk("single_done", 32'(bus.done), 32'd0);

        // start with a move in IDLE: move is dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        bus.op    = 2'b00;
        bus.SrcA  = 32'd3;
        bus.SrcB  = 32'd4;
        @(negedge clk);
        idle_inputs();
        chk("start_wins_hi", bus.hi, 32'h0000_0000);
        repeat (33) @(negedge clk);
        chk("start_wins_lo", bus.lo, 32'd12);

        // reset mid-MULT
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.SrcA  = 32'd1234;
        bus.SrcB  = 32'hFFFF_FF00;
        @(negedge clk);
        idle_inputs();
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(2'b01, 32'd6, 32'hFFFF_FFFE, 0);
        chk("after_rst_lo", bus.lo, 32'hFFFF_FFF4);
        chk("after_rst_hi", bus.hi, 32'hFFFF_FFFF);

        // randomized mix of ops and moves
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0)
                do_move(1'($urandom), 1'($urandom), $urandom);
            else
                run_op(2'($urandom), pick(), pick(), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
